// File: rtl/rcn_slave_if.sv
// rtl/rcn_slave_if.sv - local access port between rcn_slave and its peripheral
interface rcn_slave_if;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        tmo;

  modport master (
    output cs, wr, mask, addr, wdata, tmo,
    input  ack, rdata
  );

  modport slave (
    input  cs, wr, mask, addr, wdata, tmo,
    output ack, rdata
  );
endinterface

// File: rtl/rcn_slave.sv
// rtl/rcn_slave.sv - rcn ring responder: claims window hits, runs one local access, injects the response
// Optional ack timeout enabled by defining RCN_SLAVE_TIMEOUT_EN.
module rcn_slave #(
  parameter logic [21:0] ADDR_BASE = 22'h010000,
  parameter logic [21:0] ADDR_MASK = 22'h3F0000
`ifdef RCN_SLAVE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [66:0] i_rcn_in,
  output logic [66:0] o_rcn_out,
  rcn_slave_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t      r_state;
  logic [66:0] r_rin;
  logic [66:0] r_rout;
  logic [66:0] r_hold;
  logic        r_cs;
  logic        w_hit;
  logic        w_my_req;
  logic        w_expire;

  // Ring layout: {valid, pending, wr, id[5:0], seq[1:0], we[3:0], addr[21:2], data[31:0]}
  assign w_hit    = (({r_rin[51:32], 2'b00}) & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);
  assign w_my_req = r_rin[66] & r_rin[65] & w_hit;

`ifdef RCN_SLAVE_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_tmo;

  assign w_expire = (r_state == S_ACCESS) && !bus.ack && (r_cnt == 16'(TIMEOUT - 1));
  assign bus.tmo  = r_tmo;

  // Counter sits at zero outside ACCESS, so it is already cleared on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= w_expire;
      if ((r_state == S_ACCESS) && !bus.ack)
        r_cnt <= r_cnt + 16'd1;
      else
        r_cnt <= '0;
    end
  end
`else
  assign w_expire = 1'b0;
  assign bus.tmo  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rin   <= '0;
      r_rout  <= '0;
      r_hold  <= '0;
      r_cs    <= 1'b0;
    end else begin
      r_rin  <= i_rcn_in;
      r_rout <= r_rin;
      case (r_state)
        S_IDLE: begin
          if (w_my_req) begin
            r_hold  <= r_rin;
            r_rout  <= '0;
            r_cs    <= 1'b1;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Our own requests arriving now recirculate untouched via the default pass.
          if (bus.ack || w_expire) begin
            if (!r_hold[64])
              r_hold[31:0] <= bus.ack ? bus.rdata : 32'hDEAD_BEEF;
            r_hold[65] <= 1'b0;
            r_cs       <= 1'b0;
            r_state    <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (!r_rin[66]) begin
            r_rout  <= r_hold;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rcn_out = r_rout;
  assign bus.cs    = r_cs;
  assign bus.wr    = r_hold[64];
  assign bus.mask  = r_hold[55:52];
  assign bus.addr  = {r_hold[51:32], 2'b00};
  assign bus.wdata = r_hold[31:0];
endmodule

// File: tb/tb_rcn_slave.sv
// tb/tb_rcn_slave.sv - directed self-checking bench for rcn_slave
module tb_rcn_slave;
  logic        clk;
  logic        rst;
  logic [66:0] rcn_in;
  logic [66:0] rcn_out;
  int          n_chk;
  int          n_pass;

  rcn_slave_if u_if ();

  rcn_slave #(
    .ADDR_BASE(22'h010000),
    .ADDR_MASK(22'h3F0000)
`ifdef RCN_SLAVE_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .i_rcn_in (rcn_in),
    .o_rcn_out(rcn_out),
    .bus      (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [66:0] mk(input logic v, input logic p, input logic w,
                                     input logic [5:0] id, input logic [1:0] seq,
                                     input logic [3:0] we, input logic [21:0] a,
                                     input logic [31:0] d);
    return {v, p, w, id, seq, we, a[21:2], d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (rcn_out !== 67'd0) $display("FAIL rst_out got %h exp 0", rcn_out); else n_pass++;
    n_chk++; if (u_if.cs !== 1'b0) $display("FAIL rst_cs got %b exp 0", u_if.cs); else n_pass++;
    n_chk++; if (u_if.tmo !== 1'b0) $display("FAIL rst_tmo got %b exp 0", u_if.tmo); else n_pass++;
    n_chk++; if (u_if.addr !== 22'd0) $display("FAIL rst_addr got %h exp 0", u_if.addr); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_hit();
    logic [66:0] req, rsp;
    req = mk(1, 1, 0, 6'd3, 2'd1, 4'hF, 22'h010010, 32'h0);
    rsp = mk(1, 0, 0, 6'd3, 2'd1, 4'hF, 22'h010010, 32'h1234_5678);
    rcn_in = req;
    tick();
    rcn_in = '0;
    n_chk++; if (u_if.cs !== 1'b0) $display("FAIL rd_cs_early got %b exp 0", u_if.cs); else n_pass++;
    tick();
    n_chk++; if (u_if.cs !== 1'b1) $display("FAIL rd_cs got %b exp 1", u_if.cs); else n_pass++;
    n_chk++; if (u_if.wr !== 1'b0) $display("FAIL rd_wr got %b exp 0", u_if.wr); else n_pass++;
    n_chk++; if (u_if.addr !== 22'h010010) $display("FAIL rd_addr got %h exp 010010", u_if.addr); else n_pass++;
    n_chk++; if (u_if.mask !== 4'hF) $display("FAIL rd_mask got %h exp f", u_if.mask); else n_pass++;
    n_chk++; if (rcn_out !== 67'd0) $display("FAIL rd_slot_freed got %h exp 0", rcn_out); else n_pass++;
    u_if.ack = 1'b1;
    u_if.rdata = 32'h1234_5678;
    tick();
    u_if.ack = 1'b0;
    u_if.rdata = '0;
    n_chk++; if (u_if.cs !== 1'b0) $display("FAIL rd_cs_drop got %b exp 0", u_if.cs); else n_pass++;
    n_chk++; if (rcn_out !== 67'd0) $display("FAIL rd_out_pre got %h exp 0", rcn_out); else n_pass++;
    tick();
    n_chk++; if (rcn_out !== rsp) $display("FAIL rd_rsp got %h exp %h", rcn_out, rsp); else n_pass++;
    tick();
    n_chk++; if (rcn_out !== 67'd0) $display("FAIL rd_rsp_once got %h exp 0", rcn_out); else n_pass++;
  endtask

  task automatic test_write_hit();
    logic [66:0] req, rsp;
    req = mk(1, 1, 1, 6'd12, 2'd2, 4'h3, 22'h01FFFC, 32'hA5A5_0001);
    rsp = mk(1, 0, 1, 6'd12, 2'd2, 4'h3, 22'h01FFFC, 32'hA5A5_0001);
    rcn_in = req;
    tick();
    rcn_in = '0;
    tick();
    n_chk++; if (u_if.cs !== 1'b1) $display("FAIL wr_cs got %b exp 1", u_if.cs); else n_pass++;
    n_chk++; if (u_if.wr !== 1'b1) $display("FAIL wr_wr got %b exp 1", u_if.wr); else n_pass++;
    n_chk++; if (u_if.mask !== 4'h3) $display("FAIL wr_mask got %h exp 3", u_if.mask); else n_pass++;
    n_chk++; if (u_if.wdata !== 32'hA5A5_0001) $display("FAIL wr_wdata got %h exp a5a50001", u_if.wdata); else n_pass++;
    n_chk++; if (u_if.addr !== 22'h01FFFC) $display("FAIL wr_addr got %h exp 01fffc", u_if.addr); else n_pass++;
    u_if.ack = 1'b1;
    u_if.rdata = 32'hFFFF_FFFF;
    tick();
    u_if.ack = 1'b0;
    u_if.rdata = '0;
    tick();
    n_chk++; if (rcn_out !== rsp) $display("FAIL wr_rsp got %h exp %h", rcn_out, rsp); else n_pass++;
    tick();
  endtask

  task automatic test_pass_through();
    logic [66:0] v [0:3];
    logic [66:0] exp;
    v[0] = mk(1, 1, 0, 6'd7, 2'd0, 4'hF, 22'h020000, 32'h1111_1111);
    v[1] = mk(1, 0, 0, 6'd2, 2'd3, 4'hF, 22'h010020, 32'h2222_2222);
    v[2] = mk(1, 1, 1, 6'd9, 2'd2, 4'h1, 22'h3F0004, 32'h3333_3333);
    v[3] = mk(0, 1, 0, 6'd1, 2'd1, 4'hF, 22'h010008, 32'h4444_4444);
    for (int i = 0; i < 7; i++) begin
      rcn_in = (i < 4) ? v[i] : 67'd0;
      tick();
      n_chk++; if (u_if.cs !== 1'b0) $display("FAIL pass_cs[%0d] got %b exp 0", i, u_if.cs); else n_pass++;
      if (i >= 1) begin
        exp = (i - 1 < 4) ? v[i-1] : 67'd0;
        n_chk++; if (rcn_out !== exp) $display("FAIL pass_out[%0d] got %h exp %h", i, rcn_out, exp); else n_pass++;
      end
    end
  endtask

  task automatic test_busy();
    logic [66:0] a, b, rsp, exp;
    logic [66:0] fill [0:3];
    a   = mk(1, 1, 0, 6'd5, 2'd2, 4'hF, 22'h01FFF0, 32'h0);
    b   = mk(1, 1, 1, 6'd6, 2'd3, 4'h1, 22'h010004, 32'h4444_4444);
    rsp = mk(1, 0, 0, 6'd5, 2'd2, 4'hF, 22'h01FFF0, 32'hCAFE_F00D);
    for (int k = 0; k < 4; k++)
      fill[k] = mk(1, 0, 0, 6'(k), 2'd0, 4'hF, 22'h010000, 32'h0000_00F0 + k);
    rcn_in = a;
    tick();
    rcn_in = b;
    tick();
    n_chk++; if (u_if.cs !== 1'b1) $display("FAIL busy_cs got %b exp 1", u_if.cs); else n_pass++;
    rcn_in = '0;
    tick();
    n_chk++; if (rcn_out !== b) $display("FAIL busy_pass got %h exp %h", rcn_out, b); else n_pass++;
    n_chk++; if (u_if.addr !== 22'h01FFF0) $display("FAIL busy_addr got %h exp 01fff0", u_if.addr); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++; if (u_if.cs !== 1'b1) $display("FAIL busy_stall[%0d] cs got %b exp 1", i, u_if.cs); else n_pass++;
    end
    rcn_in = fill[0];
    u_if.ack = 1'b1;
    u_if.rdata = 32'hCAFE_F00D;
    tick();
    u_if.ack = 1'b0;
    u_if.rdata = '0;
    n_chk++; if (u_if.cs !== 1'b0) $display("FAIL busy_cs_drop got %b exp 0", u_if.cs); else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      rcn_in = (i < 4) ? fill[i] : 67'd0;
      tick();
      exp = (i <= 4) ? fill[i-1] : ((i == 5) ? rsp : 67'd0);
      n_chk++; if (rcn_out !== exp) $display("FAIL busy_ring[%0d] got %h exp %h", i, rcn_out, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    rcn_in = mk(1, 1, 0, 6'd8, 2'd1, 4'hF, 22'h010100, 32'h0);
    tick();
    rcn_in = '0;
    tick();
    n_chk++; if (u_if.cs !== 1'b1) $display("FAIL rmid_cs_pre got %b exp 1", u_if.cs); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (u_if.cs !== 1'b0) $display("FAIL rmid_cs_async got %b exp 0", u_if.cs); else n_pass++;
    n_chk++; if (rcn_out !== 67'd0) $display("FAIL rmid_out got %h exp 0", rcn_out); else n_pass++;
    u_if.ack = 1'b1;
    u_if.rdata = 32'h7777_7777;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++; if (rcn_out !== 67'd0) $display("FAIL rmid_quiet[%0d] got %h exp 0", i, rcn_out); else n_pass++;
      n_chk++; if (u_if.cs !== 1'b0) $display("FAIL rmid_cs[%0d] got %b exp 0", i, u_if.cs); else n_pass++;
    end
    u_if.ack = 1'b0;
    u_if.rdata = '0;
  endtask

`ifdef RCN_SLAVE_TIMEOUT_EN
  task automatic test_timeout();
    logic [66:0] rsp;
    rsp = mk(1, 0, 0, 6'd4, 2'd0, 4'hF, 22'h010040, 32'hDEAD_BEEF);
    rcn_in = mk(1, 1, 0, 6'd4, 2'd0, 4'hF, 22'h010040, 32'h0);
    tick();
    rcn_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (u_if.cs !== 1'b1 || u_if.tmo !== 1'b0) $display("FAIL to_wait[%0d] cs/tmo got %b%b exp 10", i, u_if.cs, u_if.tmo); else n_pass++;
    end
    tick();
    n_chk++; if (u_if.tmo !== 1'b1) $display("FAIL to_pulse got %b exp 1", u_if.tmo); else n_pass++;
    tick();
    n_chk++; if (u_if.tmo !== 1'b0) $display("FAIL to_pulse_end got %b exp 0", u_if.tmo); else n_pass++;
    n_chk++; if (rcn_out !== rsp) $display("FAIL to_rsp got %h exp %h", rcn_out, rsp); else n_pass++;
    tick();
    rsp = mk(1, 0, 0, 6'd4, 2'd1, 4'hF, 22'h010040, 32'h0BAD_CAFE);
    rcn_in = mk(1, 1, 0, 6'd4, 2'd1, 4'hF, 22'h010040, 32'h0);
    tick();
    rcn_in = '0;
    for (int i = 0; i < 4; i++) tick();
    u_if.ack = 1'b1;
    u_if.rdata = 32'h0BAD_CAFE;
    #0;
    u_if.ack = 1'b1;
    tick();
    u_if.ack = 1'b0;
    u_if.rdata = '0;
    n_chk++; if (u_if.tmo !== 1'b0) $display("FAIL to_ack_tmo got %b exp 0", u_if.tmo); else n_pass++;
    tick();
    n_chk++; if (rcn_out !== rsp) $display("FAIL to_ack_rsp got %h exp %h", rcn_out, rsp); else n_pass++;
    tick();
  endtask
`endif

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    rcn_in = '0;
    u_if.ack = 1'b0;
    u_if.rdata = '0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_pass_through();
    test_busy();
    test_reset_mid();
`ifdef RCN_SLAVE_TIMEOUT_EN
    test_timeout();
`endif
    n_chk++; if (u_if.tmo !== 1'b0) $display("FAIL tmo_idle got %b exp 0", u_if.tmo); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
